// File: rtl/mux_seq_serializer_pkg.sv
// mux_seq_serializer_pkg: shared FSM encoding and lane geometry
// for the serializer that sequences a 4:1 lane mux.
package mux_seq_serializer_pkg;

  localparam int NLANES = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

endpackage

// File: rtl/mux_lane_sel.sv
// mux_lane_sel: DW-wide 4:1 combinational lane selector.
// Ports: mux_din (4 lanes), mux_sel (lane index), ser_data (lane out).
module mux_lane_sel
  import mux_seq_serializer_pkg::*;
#(
  parameter int DW = 1
) (
  input  logic [NLANES*DW-1:0] mux_din,
  input  logic [SEL_W-1:0]     mux_sel,
  output logic [DW-1:0]        ser_data
);

  always_comb begin
    ser_data = '0;
    unique case (mux_sel)
      2'd0: ser_data = mux_din[0*DW +: DW];
      2'd1: ser_data = mux_din[1*DW +: DW];
      2'd2: ser_data = mux_din[2*DW +: DW];
      2'd3: ser_data = mux_din[3*DW +: DW];
      default: ser_data = '0;
    endcase
  end

endmodule

// File: rtl/mux_seq_serializer.sv
// mux_seq_serializer: loads a 4-lane word (in_valid/in_ready), steps the
// mux select one lane per accepted beat and streams lanes on ser_*.
// Ports: clk, rst_n (async low), in_valid/in_ready/load_word,
//   mux_din/mux_sel (to mux), ser_valid/ser_ready/ser_data/ser_last, busy.
// Option: define SER_PARITY_EN to append a lane-XOR parity beat.
module mux_seq_serializer
  import mux_seq_serializer_pkg::*;
#(
  parameter int DW        = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NLANES*DW-1:0] load_word,
  output logic [NLANES*DW-1:0] mux_din,
  output logic [SEL_W-1:0]     mux_sel,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic [DW-1:0]        ser_data,
  output logic                 ser_last,
  output logic                 busy
);

  localparam logic [SEL_W-1:0] FIRST_SEL =
    MSB_FIRST ? SEL_W'(NLANES - 1) : '0;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] cnt;
  logic       load;
  logic       beat;
  logic       data_beat;
  logic [DW-1:0] lane_data;

  assign load      = in_valid && in_ready;
  assign beat      = ser_valid && ser_ready;
  assign data_beat = beat && (state == ST_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
`ifndef SER_PARITY_EN
        ser_last  = (cnt == 2'd3);
`endif
        if (ser_ready && cnt == 2'd3) begin
`ifdef SER_PARITY_EN
          state_nxt = ST_PAR;
`else
          state_nxt = ST_IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PAR: begin
        ser_valid = 1'b1;
        ser_last  = 1'b1;
        busy      = 1'b1;
        if (ser_ready) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The counter ends the word; mux_sel simply wraps modulo 4 and is
  // back on the first lane once all four lanes have gone out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_din <= '0;
      mux_sel <= FIRST_SEL;
      cnt     <= 2'd0;
    end else if (load) begin
      mux_din <= load_word;
      mux_sel <= FIRST_SEL;
      cnt     <= 2'd0;
    end else if (data_beat) begin
      mux_sel <= MSB_FIRST ? mux_sel - 2'd1 : mux_sel + 2'd1;
      cnt     <= cnt + 2'd1;
    end
  end

  mux_lane_sel #(
    .DW (DW)
  ) u_lane_sel (
    .mux_din  (mux_din),
    .mux_sel  (mux_sel),
    .ser_data (lane_data)
  );

`ifdef SER_PARITY_EN
  logic [DW-1:0] parity;

  always_comb begin
    parity = '0;
    for (int k = 0; k < NLANES; k++) begin
      parity = parity ^ mux_din[k*DW +: DW];
    end
  end

  assign ser_data = (state == ST_PAR) ? parity : lane_data;
`else
  assign ser_data = lane_data;
`endif

endmodule

// File: doc/mux_seq_serializer.md
Name: mux_seq_serializer

Overview:
- Upstream sequencer for the 4:1 mux stage.
- Accepts a 4-lane word through a valid/ready handshake and holds it stable on the mux data inputs.
- Steps the mux select 0,1,2,3, one lane per accepted output beat.
- Emits each selected lane as a serial beat with its own valid/ready handshake, so the mux becomes a clocked parallel-to-serial converter.

Parameters:
- DW, 1, width of one lane in bits.
- MSB_FIRST, 0, lane order: 0 gives sel 0→3, 1 gives sel 3→0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  load_word is valid.
- in_ready  output  1  block can accept a word.
- load_word  input  4*DW  lane k = load_word[k*DW +: DW].
- mux_din  output  4*DW  registered copy of the accepted word; drives the mux data inputs.
- mux_sel  output  2  select driven to the mux.
- ser_valid  output  1  ser_data holds a valid beat.
- ser_ready  input  1  downstream accepts the beat.
- ser_data  output  DW  selected lane, produced by the internal mux instance.
- ser_last  output  1  marks the final beat of a word.
- busy  output  1  a word is in flight.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, mux_din=0, mux_sel=0 (or 3 if MSB_FIRST), beat counter=0.
  - ser_valid=0, ser_last=0, busy=0, in_ready=1.
- States:
  - IDLE: in_ready=1, ser_valid=0. On in_valid&&in_ready: latch load_word into mux_din, set mux_sel to the first lane, go to SHIFT. Load is registered, so the first beat is valid the cycle after the load handshake (latency 1).
  - SHIFT: ser_valid=1, in_ready=0, busy=1.
    - ser_data = mux_din lane[mux_sel], combinational from registers.
    - On ser_valid&&ser_ready: advance mux_sel by +1 (or −1 if MSB_FIRST) and increment the beat counter.
    - On the 4th accepted beat: go to IDLE, or to PAR when SER_PARITY_EN is defined.
    - ser_last=1 on the 4th data beat without parity; with parity it is asserted on the PAR beat instead.
  - PAR (macro only): ser_valid=1, ser_last=1, ser_data = XOR-reduction of the 4 lanes (bitwise, DW wide). On handshake go to IDLE.
- Backpressure:
  - ser_ready=0 holds mux_sel, ser_data and ser_last stable.
  - ser_valid never drops until the beat is accepted.
- No back-to-back load: in_ready is low during SHIFT/PAR. IDLE is re-entered the cycle after the last handshake, which gives 1 bubble cycle per word.
- mux_sel wrap-around: 3+1 wraps to 0 and 0−1 wraps to 3 (2-bit modulo). The counter, not mux_sel, determines the end of the word.
- in_valid asserted while busy: ignored; no latch, no state change.
- mux_din changes only on the load handshake. Lanes containing x/z pass through unaltered; there is no sanitising.
- Reset mid-word: the word is abandoned immediately, outputs return to reset values, and no partial ser_last is produced.

Optional Feature:
- Macro SER_PARITY_EN.
- Defined: a 5th beat carrying lane-XOR parity follows the 4 data beats; ser_last moves to that beat; a word takes 5 handshakes.
- Undefined: the PAR state and its logic are absent; a word is exactly 4 beats with ser_last on beat 4.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PAR=2'd2.
  - NLANES=4.
  - SEL_W=2.
- One sub-module: mux_lane_sel, a DW-wide 4:1 combinational lane selector (mux_din, mux_sel → ser_data), instantiated once.
- The FSM, counter and registers stay in the top.

Test Plan:
- Reset then load 4'b1000 (DW=1), ser_ready=1:
  - ser_data sequence 0,0,0,1 on mux_sel 0,1,2,3.
  - ser_last on beat 4.
  - in_ready returns high 1 cycle after.
- MSB_FIRST=1, load 4'b1000:
  - mux_sel 3,2,1,0.
  - ser_data 1,0,0,0.
- Backpressure: load 4'b0110, hold ser_ready=0 for 3 cycles at beat 2:
  - mux_sel stays 1 and ser_data stays 1 for all 3 cycles.
  - Sequence completes as 0,1,1,0.
- Pulse in_valid with 4'b1111 during SHIFT of word 4'b0101:
  - Output stream is 1,0,1,0 only.
  - The second word is not latched until in_ready=1.
- Assert rst_n=0 asynchronously mid-beat 2:
  - ser_valid=0, mux_sel=0, busy=0 with no clock edge required.
  - After release, a new load of 4'b0011 streams 1,1,0,0.
- With SER_PARITY_EN, DW=2, load lanes {2'b11,2'b01,2'b10,2'b00}:
  - 5 beats; the 5th carries ser_data=2'b00 with ser_last=1.
  - Load lanes {2'b01,0,0,0}: parity beat 2'b01.
